rr_port_arbiter: RTL

Round-robin arbiter that shares one memory/execution port among four requesters in the pipeline. It drives the 2-bit select of the shared 4-input operand/address mux, holds a grant until the port acknowledges, and aborts stuck transactions with a timeout. It sits between the requesting pipeline stages and the shared port, with `sel` wired directly to the mux select.

---
 rtl/rr_port_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_port_arbiter
// Brief    : Four-way round-robin arbiter for one shared port, with
//            ack-held grants and a wait-cycle timeout abort.
// Revision : 1.0
// ============================================================================
module rr_port_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mem_ack,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       mem_req,
    output logic [3:0] done,
    output logic       timeout_err,
    output logic       busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             mem_req_q, mem_req_d;
    logic [3:0]       done_q, done_d;
    logic             timeout_err_q, timeout_err_d;
    logic             busy_q, busy_d;

    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic             w_found;

    // First requester at or after the pointer, wrapping modulo 4.
    always_comb begin
        w_win   = 2'd0;
        w_idx   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_idx = ptr_q + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        gnt_d         = gnt_q;
        mem_req_d     = mem_req_q;
        busy_d        = busy_q;
        done_d        = 4'b0000;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    sel_d     = w_win;
                    gnt_d     = 4'b0001 << w_win;
                    mem_req_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Ack takes priority over an expiring counter in the same cycle.
                if (mem_ack || (cnt_q == C_CNT_LAST)) begin
                    if (mem_ack) begin
                        done_d = 4'b0001 << sel_q;
                    end else begin
                        timeout_err_d = 1'b1;
                    end
                    gnt_d     = 4'b0000;
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    ptr_d     = sel_q + 2'd1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 2'd0;
            cnt_q         <= '0;
            sel_q         <= 2'd0;
            gnt_q         <= 4'b0000;
            mem_req_q     <= 1'b0;
            done_q        <= 4'b0000;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            gnt_q         <= gnt_d;
            mem_req_q     <= mem_req_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign sel         = sel_q;
    assign gnt         = gnt_q;
    assign mem_req     = mem_req_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire
